multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 SHALL have ports: clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: opcode  input  11  instruction[31:21] from instruction register.
REQ-005 SHALL have ports: zero  input  1  ALU zero flag.
REQ-006 SHALL have ports: mem_ack  input  1  memory transfer complete this cycle.
REQ-007 SHALL have ports: mem_req  output  1  memory access request.
REQ-008 SHALL have ports: mem_we  output  1  write strobe, qualifies mem_req.
REQ-009 SHALL have ports: ir_write, pc_write, pc_src, reg2loc, alu_src, reg_write, mem_to_reg  output  1 each  datapath controls.
REQ-010 SHALL have ports: alu_op  output  2  00 add, 01 pass B, 10 R-type funct decode.
REQ-011 SHALL have ports: state  output  3  current state encoding (debug).
REQ-012 SHALL have ports: instret  output  CNT_W  retired-instruction count.
REQ-013 SHALL have ports: illegal_op  output  1  trap flag.

Function
REQ-014 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL return to FETCH.
REQ-015 SHALL decode opcode only in DECODE into a class register held until FETCH: RTYPE (10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR), ADDI (opcode[10:1]=1001000100), LDUR (11111000010), STUR (11111000000), CBZ (opcode[10:3]=10110100), CBNZ (opcode[10:3]=10110101), else ILLEGAL.
REQ-016 SHALL in FETCH: mem_req=1, mem_we=0; hold until mem_ack; on mem_ack assert ir_write same cycle and go DECODE.
REQ-017 SHALL in DECODE: reg2loc=1 iff class is STUR/CBZ/CBNZ; go EXEC (or TRAP, see Configuration).
REQ-018 SHALL in EXEC: reg2loc as in DECODE; alu_src=1 for ADDI/LDUR/STUR; alu_op=10 RTYPE, 01 CBZ/CBNZ, 00 otherwise.
REQ-019 SHALL in EXEC: RTYPE/ADDI go WB; LDUR/STUR go MEM; CBZ/CBNZ assert pc_write=1, pc_src=zero (CBZ) or ~zero (CBNZ), go FETCH.
REQ-020 SHALL in MEM: mem_req=1, mem_we=1 iff STUR, alu_src=1, alu_op=00; hold until mem_ack; then STUR asserts pc_write=1, pc_src=0, goes FETCH; LDUR goes WB.
REQ-021 SHALL in WB: reg_write=1, mem_to_reg=1 iff LDUR, pc_write=1, pc_src=0; go FETCH.
REQ-022 SHALL increment instret by 1 on each cycle a legal instruction leaves for FETCH (EXEC branch, MEM store, WB); wrap modulo 2^CNT_W.
REQ-023 SHALL drive all controls not listed for a state to 0; ir_write, pc_src and MEM/FETCH exit depend combinationally on mem_ack/zero.
REQ-024 SHALL give latencies with zero-wait memory: branch 3 cycles, RTYPE/ADDI 4, STUR 4, LDUR 5; each wait cycle adds one.
REQ-025 SHALL ignore opcode and zero outside DECODE/EXEC respectively, and ignore mem_ack outside FETCH/MEM.

Reset
REQ-026 SHALL, at a rising edge with reset=1, set state=FETCH, class=ILLEGAL, instret=0, illegal_op=0, abandoning any in-flight instruction.
REQ-027 SHALL force every control output, mem_req and ir_write to 0 combinationally while reset=1; first mem_req in first cycle after reset falls.

Configuration
REQ-028 SHALL compile trap support only when MULTICYCLE_CTRL_ILLEGAL_TRAP_EN is defined.
REQ-029 SHALL with the macro: ILLEGAL in DECODE go TRAP; TRAP drives all controls 0, illegal_op=1, stays until reset; instret frozen.
REQ-030 SHALL without the macro: ILLEGAL executes as NOP: EXEC asserts pc_write=1, pc_src=0, goes FETCH, instret not incremented; illegal_op tied 0; state never 5.

Verification
REQ-031 SHALL cover: reset then ADD (10001011000), mem_ack=1 always -> states 0,1,2,4,0; reg_write=1 in WB only; instret=1.
REQ-032 SHALL cover: LDUR (11111000010), mem_ack low 2 cycles in MEM -> MEM held 3 cycles, mem_we=0, WB mem_to_reg=1, total 7 cycles.
REQ-033 SHALL cover: CBZ zero=1 then CBNZ zero=1 -> pc_src 1 then 0, pc_write=1 in EXEC both, instret=2, no reg_write.
REQ-034 SHALL cover: STUR (11111000000) -> MEM mem_req=1, mem_we=1, next state FETCH, reg_write never 1.
REQ-035 SHALL cover: opcode 10011000000 -> with macro state=5, illegal_op=1 held 10 cycles until reset; without macro back to FETCH, instret unchanged.
REQ-036 SHALL cover: reset asserted in MEM of STUR -> mem_req=0 that cycle, state=0, instret=0 next cycle; CNT_W=4, 16 ADDIs -> instret=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// retired-instruction counter.
// Optional feature: define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to make illegal opcodes enter a
// sticky TRAP state; otherwise they execute as a NOP.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg2loc,
  output logic             alu_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             illegal_op
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsIllegal = 3'd0,
    ClsRtype   = 3'd1,
    ClsAddi    = 3'd2,
    ClsLdur    = 3'd3,
    ClsStur    = 3'd4,
    ClsCbz     = 3'd5,
    ClsCbnz    = 3'd6
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  cls_e             cls_dec, cls_cur;
  logic [CNT_W-1:0] instret_q, instret_d;

  function automatic cls_e decode(input logic [10:0] op);
    cls_e c;
    c = ClsIllegal;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) c = ClsRtype;
    else if (op[10:1] == 10'b1001000100) c = ClsAddi;
    else if (op == 11'b11111000010)      c = ClsLdur;
    else if (op == 11'b11111000000)      c = ClsStur;
    else if (op[10:3] == 8'b10110100)    c = ClsCbz;
    else if (op[10:3] == 8'b10110101)    c = ClsCbnz;
    return c;
  endfunction

  // Next-state, class capture, counter update and datapath controls.
  always_comb begin
    cls_dec    = decode(opcode);
    // DECODE sees the class combinationally; later states use the captured copy.
    cls_cur    = (state_q == StDecode) ? cls_dec : cls_q;
    state_d    = state_q;
    cls_d      = cls_q;
    instret_d  = instret_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        reg2loc = (cls_cur == ClsStur) || (cls_cur == ClsCbz) || (cls_cur == ClsCbnz);
        cls_d   = cls_dec;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        state_d = (cls_dec == ClsIllegal) ? StTrap : StExec;
`else
        state_d = StExec;
`endif
      end
      StExec: begin
        reg2loc = (cls_cur == ClsStur) || (cls_cur == ClsCbz) || (cls_cur == ClsCbnz);
        alu_src = (cls_cur == ClsAddi) || (cls_cur == ClsLdur) || (cls_cur == ClsStur);
        if (cls_cur == ClsRtype)                           alu_op = 2'b10;
        else if (cls_cur == ClsCbz || cls_cur == ClsCbnz)  alu_op = 2'b01;
        case (cls_cur)
          ClsRtype, ClsAddi: state_d = StWb;
          ClsLdur, ClsStur:  state_d = StMem;
          ClsCbz, ClsCbnz: begin
            pc_write  = 1'b1;
            pc_src    = (cls_cur == ClsCbz) ? zero : ~zero;
            state_d   = StFetch;
            instret_d = instret_q + CNT_W'(1);
          end
          default: begin
            // Illegal opcode without trap support retires silently as a NOP.
            pc_write = 1'b1;
            state_d  = StFetch;
          end
        endcase
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == ClsStur);
        alu_src = 1'b1;
        if (mem_ack) begin
          if (cls_q == ClsStur) begin
            pc_write  = 1'b1;
            state_d   = StFetch;
            instret_d = instret_q + CNT_W'(1);
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == ClsLdur);
        pc_write   = 1'b1;
        state_d    = StFetch;
        instret_d  = instret_q + CNT_W'(1);
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      StTrap: state_d = StTrap;
`endif
      default: state_d = StFetch;
    endcase

    // Reset silences every strobe in the same cycle it is asserted.
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg2loc    = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_op     = 2'b00;
    end
  end

  // State, class and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      cls_q     <= ClsIllegal;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == StTrap);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle outputs; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  localparam logic [10:0] B_RQ = 11'b10000000000;
  localparam logic [10:0] B_WE = 11'b01000000000;
  localparam logic [10:0] B_IR = 11'b00100000000;
  localparam logic [10:0] B_PW = 11'b00010000000;
  localparam logic [10:0] B_PS = 11'b00001000000;
  localparam logic [10:0] B_R2 = 11'b00000100000;
  localparam logic [10:0] B_AS = 11'b00000010000;
  localparam logic [10:0] B_RW = 11'b00000001000;
  localparam logic [10:0] B_MR = 11'b00000000100;

  localparam int C_ILL = 0, C_R = 1, C_ADDI = 2, C_LD = 3, C_ST = 4, C_CBZ = 5, C_CBNZ = 6;

  typedef struct packed {
    logic [2:0]    st;
    logic [10:0]   ctl;
    logic [CW-1:0] ret;
    logic          ill;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   opcode = '0;
  logic          zero = 1'b0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_we, ir_write, pc_write, pc_src, reg2loc, alu_src;
  logic          reg_write, mem_to_reg, illegal_op;
  logic [1:0]    alu_op;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  exp_t sb[$];
  exp_t e_exp, e_act;
  int   n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;
  int   m_ret = 0;
  int   step_idx = 0;
  int   rst_at = -1;
  bit   aborted = 0;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_op(alu_op), .state(state), .instret(instret),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sb.size() > 0) begin
      e_exp = sb.pop_front();
      e_act = '{state, {mem_req, mem_we, ir_write, pc_write, pc_src, reg2loc, alu_src,
                        reg_write, mem_to_reg, alu_op}, instret, illegal_op};
      n_chk++;
      if (e_act !== e_exp) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t: got st=%0d ctl=%b ret=%0d ill=%b, want st=%0d ctl=%b ret=%0d ill=%b",
                 $time, e_act.st, e_act.ctl, e_act.ret, e_act.ill,
                 e_exp.st, e_exp.ctl, e_exp.ret, e_exp.ill);
      end else begin
        n_pass++;
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] rop();
    return 11'($urandom);
  endfunction

  function automatic int classify(input logic [10:0] op);
    if (op inside {11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000})
      return C_R;
    if (op[10:1] == 10'b1001000100) return C_ADDI;
    if (op == 11'b11111000010) return C_LD;
    if (op == 11'b11111000000) return C_ST;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op[10:3] == 8'b10110101) return C_CBNZ;
    return C_ILL;
  endfunction

  function automatic logic [10:0] gen_op(input int k);
    logic [10:0] op;
    case (k)
      C_R: begin
        case ($urandom_range(0, 3))
          0: op = 11'b10001011000;
          1: op = 11'b11001011000;
          2: op = 11'b10001010000;
          default: op = 11'b10101010000;
        endcase
      end
      C_ADDI: op = {10'b1001000100, rb()};
      C_LD:   op = 11'b11111000010;
      C_ST:   op = 11'b11111000000;
      C_CBZ:  op = {8'b10110100, 3'($urandom)};
      C_CBNZ: op = {8'b10110101, 3'($urandom)};
      default: begin
        op = rop();
        while (classify(op) != C_ILL) op = rop();
      end
    endcase
    return op;
  endfunction

  // One clock of stimulus plus the expected outputs for that cycle.
  task automatic step(input logic [2:0] st, input logic [10:0] ctl, input logic am,
                      input logic [10:0] op, input logic z);
    logic r;
    r = (step_idx == rst_at);
    reset = r;
    mem_ack = am;
    opcode = op;
    zero = z;
    sb.push_back('{st, r ? 11'd0 : ctl, CW'(m_ret), st == 3'd5});
    @(posedge clk);
    #1;
    step_idx++;
    if (r) begin
      aborted = 1;
      m_ret = 0;
    end
  endtask

  task automatic bump();
    m_ret = (m_ret + 1) % (1 << CW);
  endtask

  // Expand one instruction into cycles following the architectural rules.
  task automatic do_instr(input logic [10:0] op, input int wf, input int wm, input logic z);
    int c;
    logic [10:0] r2, as;
    logic [1:0] ao;
    aborted = 0;
    c  = classify(op);
    r2 = (c == C_ST || c == C_CBZ || c == C_CBNZ) ? B_R2 : 11'd0;
    as = (c == C_ADDI || c == C_LD || c == C_ST) ? B_AS : 11'd0;
    ao = (c == C_R) ? 2'b10 : (c == C_CBZ || c == C_CBNZ) ? 2'b01 : 2'b00;
    for (int i = 0; i < wf; i++) begin
      step(3'd0, B_RQ, 1'b0, rop(), rb());
      if (aborted) return;
    end
    step(3'd0, B_RQ | B_IR, 1'b1, rop(), rb());
    if (aborted) return;
    step(3'd1, r2, rb(), op, rb());
    if (aborted) return;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    if (c == C_ILL) begin
      for (int i = 0; i < 10; i++) begin
        step(3'd5, 11'd0, rb(), rop(), rb());
        if (aborted) return;
      end
      rst_at = step_idx;
      step(3'd5, 11'd0, rb(), rop(), rb());
      return;
    end
`endif
    case (c)
      C_CBZ, C_CBNZ: begin
        step(3'd2, B_PW | (((c == C_CBZ) ? z : ~z) ? B_PS : 11'd0) | r2 | {9'd0, ao},
             rb(), rop(), z);
        if (!aborted) bump();
      end
      C_ILL: step(3'd2, B_PW, rb(), rop(), z);
      C_R, C_ADDI: begin
        step(3'd2, as | {9'd0, ao}, rb(), rop(), z);
        if (aborted) return;
        step(3'd4, B_RW | B_PW, rb(), rop(), rb());
        if (!aborted) bump();
      end
      default: begin
        step(3'd2, r2 | as, rb(), rop(), z);
        if (aborted) return;
        for (int i = 0; i < wm; i++) begin
          step(3'd3, B_RQ | B_AS | ((c == C_ST) ? B_WE : 11'd0), 1'b0, rop(), rb());
          if (aborted) return;
        end
        if (c == C_ST) begin
          step(3'd3, B_RQ | B_WE | B_AS | B_PW, 1'b1, rop(), rb());
          if (!aborted) bump();
        end else begin
          step(3'd3, B_RQ | B_AS, 1'b1, rop(), rb());
          if (aborted) return;
          step(3'd4, B_RW | B_MR | B_PW, rb(), rop(), rb());
          if (!aborted) bump();
        end
      end
    endcase
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    // Reset held: state FETCH, strobes silent, counter cleared.
    rst_at = step_idx;
    step(3'd0, B_RQ, 1'b1, rop(), rb());
    rst_at = -1;

    do_instr(11'b10001011000, 0, 0, 1'b0);          // ADD, zero-wait
    do_instr(11'b11111000010, 0, 2, 1'b0);          // LDUR, two MEM wait cycles
    do_instr(11'b10110100000, 0, 0, 1'b1);          // CBZ taken
    do_instr(11'b10110101000, 0, 0, 1'b1);          // CBNZ not taken
    do_instr(11'b11111000000, 1, 0, 1'b0);          // STUR, one fetch wait
    do_instr(11'b10011000000, 0, 0, 1'b0);          // illegal opcode
    rst_at = step_idx + 3;                          // reset lands in MEM of STUR
    do_instr(11'b11111000000, 0, 0, 1'b0);
    rst_at = -1;
    for (int i = 0; i < 16; i++) do_instr(gen_op(C_ADDI), 0, 0, rb());
    do_instr(11'b10001010000, 0, 0, 1'b0);          // counter wrapped to 0 here

    for (int n = 0; n < 300; n++) begin
      logic [10:0] op;
      op = gen_op($urandom_range(0, 6));
      rst_at = ($urandom_range(0, 19) == 0) ? step_idx + $urandom_range(0, 6) : -1;
      do_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), rb());
      rst_at = -1;
    end

    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
